dmem_rr_arbiter: RTL and testbench

//  Shares the single data-memory/atomic-unit port between CORE_NUMS cores using round-robin arbitration.

---
 rtl/dmem_rr_arbiter.sv | 156 +++++++++++++++
 tb/tb_dmem_rr_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter sharing one data-memory/atomic-unit port between CORE_NUMS cores.
// Each core posts a one-cycle request into its own slot; one transaction is in flight at a time.
module dmem_rr_arbiter #(
    parameter int CORE_NUMS      = 4,
    parameter int CORE_NUMS_BITS = 2,
    parameter int XLEN           = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [CORE_NUMS-1:0]        P_strobe_i,
    input  logic [CORE_NUMS*XLEN-1:0]   P_addr_i,
    input  logic [CORE_NUMS-1:0]        P_rw_i,
    input  logic [CORE_NUMS*XLEN-1:0]   P_data_i,
    input  logic [CORE_NUMS-1:0]        P_is_amo_i,
    input  logic [CORE_NUMS*5-1:0]      P_amo_type_i,
    output logic [CORE_NUMS-1:0]        P_done_o,
    output logic [XLEN-1:0]             P_data_o,
    output logic [CORE_NUMS_BITS-1:0]   M_core_id_o,
    output logic                        M_strobe_o,
    output logic [XLEN-1:0]             M_addr_o,
    output logic                        M_rw_o,
    output logic [XLEN-1:0]             M_data_o,
    output logic                        M_is_amo_o,
    output logic [4:0]                  M_amo_type_o,
    input  logic                        M_done_i,
    input  logic [XLEN-1:0]             M_data_i
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                       state_reg, state_next;
    logic [CORE_NUMS_BITS-1:0]    gnt_reg, gnt_next;
    logic [CORE_NUMS_BITS-1:0]    last_grant_reg, last_grant_next;
    logic [CORE_NUMS-1:0]         pend_reg, pend_clr, capture_en;
    logic [XLEN-1:0]              rdata_reg;

    logic [XLEN-1:0]              in_addr [CORE_NUMS];
    logic [XLEN-1:0]              in_data [CORE_NUMS];
    logic [4:0]                   in_type [CORE_NUMS];

    logic [XLEN-1:0]              addr_reg [CORE_NUMS];
    logic [XLEN-1:0]              data_reg [CORE_NUMS];
    logic [4:0]                   type_reg [CORE_NUMS];
    logic [CORE_NUMS-1:0]         rw_reg, amo_reg;

    logic                         sel_valid;
    logic [CORE_NUMS_BITS-1:0]    sel_idx, cand_idx;
    int                           cand;

    genvar gi;
    generate
        for (gi = 0; gi < CORE_NUMS; gi++) begin : g_core
            assign in_addr[gi]    = P_addr_i[gi*XLEN +: XLEN];
            assign in_data[gi]    = P_data_i[gi*XLEN +: XLEN];
            assign in_type[gi]    = P_amo_type_i[gi*5 +: 5];
            // A strobe from a core that is still pending is dropped; its slot stays intact.
            assign capture_en[gi] = P_strobe_i[gi] & ~pend_reg[gi];
            assign P_done_o[gi]   = (state_reg == S_RESP) && (gnt_reg == CORE_NUMS_BITS'(gi));
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_reg <= '0;
        end else begin
            pend_reg <= (pend_reg | capture_en) & ~pend_clr;
        end
        for (int k = 0; k < CORE_NUMS; k++) begin
            if (capture_en[k]) begin
                addr_reg[k] <= in_addr[k];
                data_reg[k] <= in_data[k];
                type_reg[k] <= in_type[k];
                rw_reg[k]   <= P_rw_i[k];
                amo_reg[k]  <= P_is_amo_i[k];
            end
        end
    end

    // First pending core strictly after last_grant, wrapping around.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= CORE_NUMS; i++) begin
            cand = int'(last_grant_reg) + i;
            if (cand >= CORE_NUMS) cand = cand - CORE_NUMS;
            cand_idx = CORE_NUMS_BITS'(cand);
            if (!sel_valid && pend_reg[cand_idx]) begin
                sel_valid = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= S_IDLE;
            gnt_reg        <= '0;
            last_grant_reg <= CORE_NUMS_BITS'(CORE_NUMS - 1);
            rdata_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            gnt_reg        <= gnt_next;
            last_grant_reg <= last_grant_next;
            if (state_reg == S_WAIT && M_done_i) rdata_reg <= M_data_i;
        end
    end

    always_comb begin
        state_next      = state_reg;
        gnt_next        = gnt_reg;
        last_grant_next = last_grant_reg;
        pend_clr        = '0;
        case (state_reg)
            S_IDLE: begin
                if (sel_valid) begin
                    gnt_next   = sel_idx;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                if (M_done_i) state_next = S_RESP;
            end
            S_RESP: begin
                pend_clr[gnt_reg] = 1'b1;
                last_grant_next   = gnt_reg;
                state_next        = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Request fields are held from the granted slot for the whole transaction.
    always_comb begin
        M_strobe_o   = (state_reg == S_ISSUE);
        M_core_id_o  = '0;
        M_addr_o     = '0;
        M_rw_o       = 1'b0;
        M_data_o     = '0;
        M_is_amo_o   = 1'b0;
        M_amo_type_o = '0;
        P_data_o     = '0;
        if (state_reg != S_IDLE) begin
            M_core_id_o  = gnt_reg;
            M_addr_o     = addr_reg[gnt_reg];
            M_rw_o       = rw_reg[gnt_reg];
            M_data_o     = data_reg[gnt_reg];
            M_is_amo_o   = amo_reg[gnt_reg];
            M_amo_type_o = type_reg[gnt_reg];
        end
        if (state_reg == S_RESP) P_data_o = rdata_reg;
    end

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Directed bench for dmem_rr_arbiter: table-driven grant-order scenarios plus
// hand-written latency, AMO-hold, reset and duplicate-strobe sequences.
module tb_dmem_rr_arbiter;
    localparam int N  = 4;
    localparam int NB = 2;
    localparam int XL = 32;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [N-1:0]      P_strobe_i;
    logic [N*XL-1:0]   P_addr_i;
    logic [N-1:0]      P_rw_i;
    logic [N*XL-1:0]   P_data_i;
    logic [N-1:0]      P_is_amo_i;
    logic [N*5-1:0]    P_amo_type_i;
    logic [N-1:0]      P_done_o;
    logic [XL-1:0]     P_data_o;
    logic [NB-1:0]     M_core_id_o;
    logic              M_strobe_o;
    logic [XL-1:0]     M_addr_o;
    logic              M_rw_o;
    logic [XL-1:0]     M_data_o;
    logic              M_is_amo_o;
    logic [4:0]        M_amo_type_o;
    logic              M_done_i;
    logic [XL-1:0]     M_data_i;

    dmem_rr_arbiter #(.CORE_NUMS(N), .CORE_NUMS_BITS(NB), .XLEN(XL)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .P_strobe_i(P_strobe_i), .P_addr_i(P_addr_i), .P_rw_i(P_rw_i),
        .P_data_i(P_data_i), .P_is_amo_i(P_is_amo_i), .P_amo_type_i(P_amo_type_i),
        .P_done_o(P_done_o), .P_data_o(P_data_o),
        .M_core_id_o(M_core_id_o), .M_strobe_o(M_strobe_o), .M_addr_o(M_addr_o),
        .M_rw_o(M_rw_o), .M_data_o(M_data_o), .M_is_amo_o(M_is_amo_o),
        .M_amo_type_o(M_amo_type_o), .M_done_i(M_done_i), .M_data_i(M_data_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [XL-1:0] exp_addr [N];
    logic [XL-1:0] exp_data [N];
    logic [4:0]    exp_type [N];
    logic          exp_rw   [N];
    logic          exp_amo  [N];

    typedef struct {
        int          prime;   // core served first to set last_grant, -1 for none
        logic [3:0]  mask;    // cores strobing together afterwards
        int          n;       // number of expected grants
        logic [7:0]  order;   // expected grant sequence, 2 bits per grant, first in [1:0]
    } vec_t;
    vec_t vecs [5];

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_fields(input int core);
        chk("core_id", 32'(M_core_id_o), core);
        chk("addr", M_addr_o, exp_addr[core]);
        chk("rw", 32'(M_rw_o), 32'(exp_rw[core]));
        chk("wdata", M_data_o, exp_data[core]);
        chk("is_amo", 32'(M_is_amo_o), 32'(exp_amo[core]));
        chk("amo_type", 32'(M_amo_type_o), 32'(exp_type[core]));
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_strobe"}, 32'(M_strobe_o), 0);
        chk({tag, "_core_id"}, 32'(M_core_id_o), 0);
        chk({tag, "_addr"}, M_addr_o, 0);
        chk({tag, "_wdata"}, M_data_o, 0);
        chk({tag, "_rw_amo"}, {30'd0, M_rw_o, M_is_amo_o}, 0);
        chk({tag, "_amo_type"}, 32'(M_amo_type_o), 0);
        chk({tag, "_p_done"}, 32'(P_done_o), 0);
        chk({tag, "_p_data"}, P_data_o, 0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1; P_strobe_i = '0; M_done_i = 1'b0; M_data_i = '0;
        tick();
        tick();
        check_idle_outputs("reset");
        rst_i = 1'b0;
    endtask

    task automatic set_fields(input int core, input logic [31:0] addr, input logic rw,
                              input logic [31:0] data, input logic amo, input logic [4:0] typ,
                              input bit upd);
        P_addr_i[core*XL +: XL]  = addr;
        P_data_i[core*XL +: XL]  = data;
        P_amo_type_i[core*5 +: 5] = typ;
        P_rw_i[core]     = rw;
        P_is_amo_i[core] = amo;
        if (upd) begin
            exp_addr[core] = addr; exp_data[core] = data; exp_type[core] = typ;
            exp_rw[core]   = rw;   exp_amo[core]  = amo;
        end
    endtask

    task automatic post_one(input int core, input logic [31:0] addr, input logic rw,
                            input logic [31:0] data, input logic amo, input logic [4:0] typ,
                            input bit upd);
        set_fields(core, addr, rw, data, amo, typ, upd);
        P_strobe_i = '0;
        P_strobe_i[core] = 1'b1;
        tick();
        P_strobe_i = '0;
    endtask

    task automatic post(input logic [3:0] mask, input logic [31:0] base);
        for (int k = 0; k < N; k++)
            if (mask[k])
                set_fields(k, base + 32'(k * 4), k[0], 32'hA000_0000 | 32'(k << 8) | base,
                           1'b0, 5'(k), 1'b1);
        P_strobe_i = mask;
        tick();
        P_strobe_i = '0;
    endtask

    task automatic expect_quiet(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            chk("quiet_strobe", 32'(M_strobe_o), 0);
            chk("quiet_done", 32'(P_done_o), 0);
            tick();
        end
    endtask

    task automatic serve(input int core, input int dly, input logic [31:0] rd);
        int waited;
        waited = 0;
        while (M_strobe_o !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        chk("grant_seen", 32'(waited < 20), 1);
        if (waited >= 20) return;
        check_fields(core);
        tick();
        for (int i = 0; i < dly; i++) begin
            chk("strobe_in_wait", 32'(M_strobe_o), 0);
            chk("done_in_wait", 32'(P_done_o), 0);
            check_fields(core);
            tick();
        end
        M_done_i = 1'b1; M_data_i = rd;
        check_fields(core);
        tick();
        M_done_i = 1'b0; M_data_i = '0;
        chk("p_done", 32'(P_done_o), 32'(1 << core));
        chk("p_data", P_data_o, rd);
        check_fields(core);
        $display("txn core=%0d addr=%h rdata=%h done=%b", core, M_addr_o, P_data_o, P_done_o);
        tick();
        chk("p_done_clear", 32'(P_done_o), 0);
        chk("p_data_clear", P_data_o, 0);
        chk("core_id_idle", 32'(M_core_id_o), 0);
    endtask

    initial begin
        rst_i = 1'b1; P_strobe_i = '0; P_addr_i = '0; P_rw_i = '0; P_data_i = '0;
        P_is_amo_i = '0; P_amo_type_i = '0; M_done_i = 1'b0; M_data_i = '0;
        for (int k = 0; k < N; k++) begin
            exp_addr[k] = '0; exp_data[k] = '0; exp_type[k] = '0; exp_rw[k] = 1'b0; exp_amo[k] = 1'b0;
        end

        vecs[0] = '{prime: -1, mask: 4'b1111, n: 4, order: {2'd3, 2'd2, 2'd1, 2'd0}};
        vecs[1] = '{prime:  1, mask: 4'b1001, n: 2, order: {2'd0, 2'd0, 2'd0, 2'd3}};
        vecs[2] = '{prime:  2, mask: 4'b1111, n: 4, order: {2'd2, 2'd1, 2'd0, 2'd3}};
        vecs[3] = '{prime:  3, mask: 4'b0110, n: 2, order: {2'd0, 2'd0, 2'd2, 2'd1}};
        vecs[4] = '{prime:  0, mask: 4'b0001, n: 1, order: {2'd0, 2'd0, 2'd0, 2'd0}};

        // Single-read latency sequence with exact cycle positions.
        do_reset();
        tick();
        post_one(2, 32'h100, 1'b0, 32'h0, 1'b0, 5'd0, 1'b1);
        chk("lat_t1_strobe", 32'(M_strobe_o), 0);
        tick();
        chk("lat_t2_strobe", 32'(M_strobe_o), 1);
        check_fields(2);
        tick();
        chk("lat_t3_strobe", 32'(M_strobe_o), 0);
        tick();
        tick();
        M_done_i = 1'b1; M_data_i = 32'hDEAD;
        chk("lat_d_pdone", 32'(P_done_o), 0);
        tick();
        M_done_i = 1'b0; M_data_i = '0;
        chk("lat_d1_pdone", 32'(P_done_o), 32'b0100);
        chk("lat_d1_pdata", P_data_o, 32'hDEAD);
        $display("txn core=2 addr=%h rdata=%h done=%b", M_addr_o, P_data_o, P_done_o);
        tick();
        chk("lat_d2_pdone", 32'(P_done_o), 0);
        chk("lat_d2_pdata", P_data_o, 0);

        // Table-driven round-robin order scenarios.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            tick();
            if (vecs[v].prime >= 0) begin
                post(4'(1 << vecs[v].prime), 32'h0000_0300);
                serve(vecs[v].prime, 1, 32'h5000_0000 | 32'(v));
            end
            post(vecs[v].mask, 32'h1000 + 32'(v * 32'h40));
            for (int j = 0; j < vecs[v].n; j++)
                serve(int'(vecs[v].order[2*j +: 2]), (v + j) % 3, 32'hC0DE_0000 | 32'(v * 16 + j));
            expect_quiet(6);
        end

        // AMO field hold across a long downstream delay.
        do_reset();
        tick();
        post_one(1, 32'h40, 1'b0, 32'h5, 1'b1, 5'b00000, 1'b1);
        serve(1, 6, 32'h1234_5678);
        expect_quiet(4);

        // Reset while a transaction waits and another core is pending.
        do_reset();
        tick();
        post(4'b0101, 32'h200);
        for (int w = 0; w < 20 && M_strobe_o !== 1'b1; w++) tick();
        chk("rst_seq_grant", 32'(M_core_id_o), 0);
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        check_idle_outputs("midrst");
        rst_i = 1'b0;
        expect_quiet(6);
        post_one(3, 32'h3C0, 1'b1, 32'hFACE, 1'b0, 5'd0, 1'b1);
        serve(3, 2, 32'h0000_0033);
        expect_quiet(6);

        // Duplicate strobe while pending: second request must be dropped.
        do_reset();
        tick();
        post_one(0, 32'h80, 1'b0, 32'h11, 1'b0, 5'd0, 1'b1);
        post_one(0, 32'h84, 1'b1, 32'h22, 1'b1, 5'd3, 1'b0);
        serve(0, 2, 32'h0000_0080);
        expect_quiet(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
